// File: rtl/execute_unit.sv
// execute_unit: RV32 execute stage with internal 32x32 register file, single-cycle ALU and registered result
module execute_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [1:0]      op_type,
  input  logic [3:0]      op_func,
  input  logic [4:0]      op_rs1,
  input  logic [4:0]      op_rs2,
  input  logic [4:0]      op_dest,
  input  logic            op_use_imm,
  input  logic [XLEN-1:0] op_imm,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_dest,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] a, b, result;
  logic            func_ok, accept, reject;
  // operand fetch, legality decode and ALU; x0 always reads as zero
  always_comb begin
    a       = (op_rs1 == '0) ? '0 : rf[op_rs1];
    b       = op_use_imm ? op_imm : ((op_rs2 == '0) ? '0 : rf[op_rs2]);
    func_ok = op_func <= 4'd9;
    accept  = op_valid && op_type == 2'd1 && func_ok;
    reject  = op_valid && (op_type[1] || (op_type == 2'd1 && !func_ok));
    result  = '0;
    case (op_func)
      4'd0: result = a + b;
      4'd1: result = a - b;
      4'd2: result = a << b[4:0];
      4'd3: result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd4: result = {{(XLEN-1){1'b0}}, a < b};
      4'd5: result = a ^ b;
      4'd6: result = a >> b[4:0];
      4'd7: result = $unsigned($signed(a) >>> b[4:0]);
      4'd8: result = a | b;
      4'd9: result = a & b;
      default: result = '0;
    endcase
    dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];
  end
  // write-back and result registers; reset wins over an op in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_dest  <= '0;
      illegal   <= 1'b0;
    end else begin
      res_valid <= accept;
      illegal   <= reject;
      if (accept) begin
        res_data <= result;
        res_dest <= op_dest;
        if (op_dest != '0) rf[op_dest] <= result;
      end
    end
  end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: table-driven directed check of execute_unit
module tb_execute_unit;
  logic        clk = 1'b0;
  logic        rst, op_valid, op_use_imm;
  logic [1:0]  op_type;
  logic [3:0]  op_func;
  logic [4:0]  op_rs1, op_rs2, op_dest, dbg_addr, res_dest;
  logic [31:0] op_imm, res_data, dbg_data;
  logic        res_valid, illegal;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic        rst, valid;
    logic [1:0]  typ;
    logic [3:0]  func;
    logic [4:0]  rs1, rs2, dest;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  dbg;
    logic        ev;
    logic [31:0] ed;
    logic [4:0]  edest;
    logic        eill;
    logic [31:0] edbg;
  } vec_t;

  vec_t vq[$];

  execute_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type), .op_func(op_func),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_dest(op_dest), .op_use_imm(op_use_imm),
    .op_imm(op_imm), .res_valid(res_valid), .res_data(res_data), .res_dest(res_dest),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic vl, logic [1:0] t, logic [3:0] f,
                             logic [4:0] s1, logic [4:0] s2, logic [4:0] d, logic ui,
                             logic [31:0] im, logic [4:0] dba, logic ev, logic [31:0] ed,
                             logic [4:0] edest, logic eill, logic [31:0] edbg);
    vec_t x;
    x.rst = r; x.valid = vl; x.typ = t; x.func = f; x.rs1 = s1; x.rs2 = s2; x.dest = d;
    x.use_imm = ui; x.imm = im; x.dbg = dba; x.ev = ev; x.ed = ed; x.edest = edest;
    x.eill = eill; x.edbg = edbg;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic dbg_sweep(string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 check($sformatf("%s dbg x%0d", tag, i), dbg_data, 32'h0);
    end
  endtask

  initial begin
    // rst vld typ fn rs1 rs2 dst imm? imm dbg | v data dest ill dbg
    vq.push_back(v(1,0,0,0, 0,0,0, 0,32'h0,        0, 0,32'h0,0,0,32'h0));
    vq.push_back(v(0,1,1,0, 0,0,1, 1,32'd5,        1, 1,32'd5,1,0,32'd5));
    vq.push_back(v(0,1,1,0, 0,0,2, 1,32'd7,        2, 1,32'd7,2,0,32'd7));
    vq.push_back(v(0,1,1,0, 1,2,3, 0,32'h0,        3, 1,32'd12,3,0,32'd12));
    vq.push_back(v(0,1,1,0, 0,0,1, 1,32'h80000000, 1, 1,32'h80000000,1,0,32'h80000000));
    vq.push_back(v(0,1,1,1, 0,1,4, 0,32'h0,        4, 1,32'h80000000,4,0,32'h80000000));
    vq.push_back(v(0,1,1,7, 1,0,5, 1,32'd4,        5, 1,32'hF8000000,5,0,32'hF8000000));
    vq.push_back(v(0,1,1,6, 1,0,5, 1,32'd4,        5, 1,32'h08000000,5,0,32'h08000000));
    vq.push_back(v(0,1,1,2, 1,0,5, 1,32'd33,       5, 1,32'h0,5,0,32'h0));
    vq.push_back(v(0,1,1,0, 0,0,6, 1,32'hFFFFFFFF, 6, 1,32'hFFFFFFFF,6,0,32'hFFFFFFFF));
    vq.push_back(v(0,1,1,0, 0,0,7, 1,32'd1,        7, 1,32'd1,7,0,32'd1));
    vq.push_back(v(0,1,1,3, 6,7,8, 0,32'h0,        8, 1,32'd1,8,0,32'd1));
    vq.push_back(v(0,1,1,4, 6,7,8, 0,32'h0,        8, 1,32'd0,8,0,32'd0));
    vq.push_back(v(0,1,1,0, 7,6,9, 0,32'h0,        9, 1,32'd0,9,0,32'd0));
    vq.push_back(v(0,1,1,5, 6,0,10,1,32'h0F0F0F0F, 10,1,32'hF0F0F0F0,10,0,32'hF0F0F0F0));
    vq.push_back(v(0,1,1,8, 2,1,11,0,32'h0,        11,1,32'h80000007,11,0,32'h80000007));
    vq.push_back(v(0,1,1,9, 6,2,12,0,32'h0,        12,1,32'd7,12,0,32'd7));
    vq.push_back(v(0,1,1,0, 0,0,0, 1,32'd9,        0, 1,32'd9,0,0,32'h0));
    vq.push_back(v(0,1,1,12,1,0,13,1,32'd1,        13,0,32'd9,0,1,32'h0));
    vq.push_back(v(0,1,2,0, 1,0,13,1,32'd1,        13,0,32'd9,0,1,32'h0));
    vq.push_back(v(0,0,1,0, 1,0,14,1,32'd1,        1, 0,32'd9,0,0,32'h80000000));
    vq.push_back(v(0,1,0,0, 1,0,14,1,32'd1,        14,0,32'd9,0,0,32'h0));
    vq.push_back(v(0,1,1,0, 0,0,14,1,32'd3,        14,1,32'd3,14,0,32'd3));
    vq.push_back(v(1,1,1,0, 0,0,1, 1,32'd3,        1, 0,32'h0,0,0,32'h0));

    rst = 1'b1; op_valid = 1'b0; op_type = '0; op_func = '0; op_rs1 = '0; op_rs2 = '0;
    op_dest = '0; op_use_imm = 1'b0; op_imm = '0; dbg_addr = '0;
    @(posedge clk);
    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      rst = vq[k].rst; op_valid = vq[k].valid; op_type = vq[k].typ; op_func = vq[k].func;
      op_rs1 = vq[k].rs1; op_rs2 = vq[k].rs2; op_dest = vq[k].dest;
      op_use_imm = vq[k].use_imm; op_imm = vq[k].imm; dbg_addr = vq[k].dbg;
      @(posedge clk);
      #1;
      check($sformatf("v%0d res_valid", k), 32'(res_valid), 32'(vq[k].ev));
      check($sformatf("v%0d res_data", k), res_data, vq[k].ed);
      check($sformatf("v%0d res_dest", k), 32'(res_dest), 32'(vq[k].edest));
      check($sformatf("v%0d illegal", k), 32'(illegal), 32'(vq[k].eill));
      check($sformatf("v%0d dbg_data", k), dbg_data, vq[k].edbg);
      if (k == 0) dbg_sweep("reset");
    end
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    dbg_sweep("rst_with_op");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
